// File: rtl/irq_pending_arbiter.sv
// rtl/irq_pending_arbiter.sv - 8-line edge-capturing pending register with highest-index grant FSM
// Optional masking via IRQ_PENDING_ARBITER_MASK_EN (adds mask_in, 1 = enabled).
module irq_pending_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_in,
`ifdef IRQ_PENDING_ARBITER_MASK_EN
  input  logic [7:0] mask_in,
`endif
  input  logic       irq_ready,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic       ovf
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0] r_state;
  logic [7:0] r_req_prev;
  logic [7:0] r_pending;
  logic [2:0] r_irq_id;
  logic       r_ovf;

  logic [7:0] w_edge;
  logic [7:0] w_clr;
  logic [7:0] w_eligible;
  logic [2:0] w_top;
  logic       w_ovf_hit;

  assign w_edge = req_in & ~r_req_prev;

  // Clear of the presented bit loses to a coincident edge on the same bit.
  assign w_clr     = (r_state == ST_PRESENT && irq_ready) ? (8'b1 << r_irq_id) : 8'b0;
  assign w_ovf_hit = |(w_edge & r_pending & ~w_clr);

`ifdef IRQ_PENDING_ARBITER_MASK_EN
  assign w_eligible = r_pending & mask_in;
`else
  assign w_eligible = r_pending;
`endif

  always_comb begin
    w_top = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_eligible[i]) w_top = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_req_prev <= 8'h00;
      r_pending  <= 8'h00;
      r_irq_id   <= 3'd0;
      r_ovf      <= 1'b0;
    end else begin
      r_req_prev <= req_in;
      r_pending  <= (r_pending & ~w_clr) | w_edge;
      if (w_ovf_hit) r_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (|w_eligible) begin
            r_irq_id <= w_top;
            r_state  <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (irq_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign irq_valid = (r_state == ST_PRESENT);
  assign irq_id    = r_irq_id;
  assign pending   = r_pending;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb/tb_irq_pending_arbiter.sv - directed and randomized checks of irq_pending_arbiter against a reference model
module tb_irq_pending_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_in = 8'h00;
  logic [7:0] mask_in = 8'hFF;
  logic       irq_ready = 1'b0;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic       ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_pend [8];
  bit m_prev [8];
  bit m_valid;
  int m_id;
  bit m_ovf;

  irq_pending_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
`ifdef IRQ_PENDING_ARBITER_MASK_EN
    .mask_in   (mask_in),
`endif
    .irq_ready (irq_ready),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_pending();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One clock edge of the behaviour: edges set, presented bit clears on handshake,
  // grant picks highest eligible bit from the pending set seen before this edge.
  task automatic model_edge(input bit r, input logic [7:0] rq, input bit rdy, input logic [7:0] mk);
    bit old_pend [8];
    int clr;
    int top;
    if (r) begin
      for (int i = 0; i < 8; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
      m_valid = 0; m_id = 0; m_ovf = 0;
      return;
    end
    old_pend = m_pend;
    clr = (m_valid && rdy) ? m_id : -1;
    for (int i = 0; i < 8; i++) begin
      if (rq[i] && !m_prev[i]) begin
        if (old_pend[i] && i != clr) m_ovf = 1;
        m_pend[i] = 1;
      end else if (i == clr) begin
        m_pend[i] = 0;
      end
      m_prev[i] = rq[i];
    end
    if (m_valid) begin
      if (rdy) m_valid = 0;
    end else begin
      top = -1;
      for (int i = 0; i < 8; i++) if (old_pend[i] && mk[i]) top = i;
      if (top >= 0) begin m_valid = 1; m_id = top; end
    end
  endtask

  // Apply inputs just after a falling edge, take one rising edge, compare at the next falling edge.
  task automatic step(input bit r, input logic [7:0] rq, input bit rdy, input logic [7:0] mk);
    logic [7:0] eff_mk;
`ifdef IRQ_PENDING_ARBITER_MASK_EN
    eff_mk = mk;
`else
    eff_mk = 8'hFF;
`endif
    rst = r; req_in = rq; irq_ready = rdy; mask_in = mk;
    model_edge(r, rq, rdy, eff_mk);
    @(posedge clk);
    @(negedge clk);
    check("valid", {31'd0, irq_valid}, {31'd0, m_valid});
    if (m_valid) check("id", {29'd0, irq_id}, m_id);
    check("pending", {24'd0, pending}, {24'd0, model_pending()});
    check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  function automatic logic [31:0] vi(input logic v, input logic [2:0] id);
    return {28'd0, v, id};
  endfunction

  int idle_gap;
  logic [7:0] r_req;

  initial begin
    @(negedge clk);
    // Reset state
    step(1, 8'h00, 0, 8'hFF);
    check("rst_valid", {31'd0, irq_valid}, 0);
    check("rst_id", {29'd0, irq_id}, 0);
    check("rst_pending", {24'd0, pending}, 0);

    // Single request, two-edge latency, handshake clears
    step(0, 8'h01, 0, 8'hFF);
    check("lat_pend", {24'd0, pending}, 32'h01);
    check("lat_e1", vi(irq_valid, irq_id), vi(0, 0));
    step(0, 8'h00, 0, 8'hFF);
    check("lat_e2", vi(irq_valid, irq_id), vi(1, 0));
    step(0, 8'h00, 1, 8'hFF);
    check("clr_valid", {31'd0, irq_valid}, 0);
    check("clr_pend", {24'd0, pending}, 0);

    // Three simultaneous edges granted 7,4,2 with one idle cycle between
    step(0, 8'h00, 1, 8'hFF);
    step(0, 8'h94, 1, 8'hFF);
    check("seq_pend", {24'd0, pending}, 32'h94);
    step(0, 8'h00, 1, 8'hFF); check("seq_g7", vi(irq_valid, irq_id), vi(1, 7));
    step(0, 8'h00, 1, 8'hFF); check("seq_gap1", {31'd0, irq_valid}, 0);
    step(0, 8'h00, 1, 8'hFF); check("seq_g4", vi(irq_valid, irq_id), vi(1, 4));
    step(0, 8'h00, 1, 8'hFF); check("seq_gap2", {31'd0, irq_valid}, 0);
    step(0, 8'h00, 1, 8'hFF); check("seq_g2", vi(irq_valid, irq_id), vi(1, 2));
    step(0, 8'h00, 1, 8'hFF); check("seq_end", {24'd0, pending}, 0);

    // Higher edge during presentation does not disturb irq_id
    step(1, 8'h00, 0, 8'hFF);
    step(0, 8'h08, 0, 8'hFF);
    step(0, 8'h00, 0, 8'hFF); check("hold_g3", vi(irq_valid, irq_id), vi(1, 3));
    step(0, 8'h40, 0, 8'hFF); check("hold_id", vi(irq_valid, irq_id), vi(1, 3));
    check("hold_pend", {24'd0, pending}, 32'h48);
    step(0, 8'h00, 1, 8'hFF);
    step(0, 8'h00, 0, 8'hFF); check("hold_g6", vi(irq_valid, irq_id), vi(1, 6));

    // Overflow on repeated edge; single grant
    step(1, 8'h00, 0, 8'hFF);
    step(0, 8'h20, 0, 8'hFF);
    step(0, 8'h00, 0, 8'hFF);
    step(0, 8'h20, 0, 8'hFF); check("ovf_set", {31'd0, ovf}, 1);
    step(0, 8'h00, 1, 8'hFF);
    step(0, 8'h00, 0, 8'hFF); check("ovf_one_grant", {31'd0, irq_valid}, 0);

    // Edge coinciding with clear: set wins, no overflow
    step(1, 8'h00, 0, 8'hFF);
    step(0, 8'h20, 0, 8'hFF);
    step(0, 8'h00, 0, 8'hFF);
    step(0, 8'h20, 1, 8'hFF);
    check("coin_pend", {24'd0, pending}, 32'h20);
    check("coin_ovf", {31'd0, ovf}, 0);
    step(0, 8'h00, 0, 8'hFF); check("coin_regrant", vi(irq_valid, irq_id), vi(1, 5));

    // Reset beats handshake; held line registers after release
    step(1, 8'h00, 0, 8'hFF);
    step(0, 8'hFF, 0, 8'hFF);
    step(0, 8'h00, 0, 8'hFF);
    step(1, 8'h80, 1, 8'hFF);
    check("rh_all", {irq_valid, irq_id, ovf, pending}, 0);
    step(0, 8'h80, 0, 8'hFF); check("rh_pend", {24'd0, pending}, 32'h80);

`ifdef IRQ_PENDING_ARBITER_MASK_EN
    step(1, 8'h00, 0, 8'h0F);
    step(0, 8'h82, 0, 8'h0F);
    step(0, 8'h00, 0, 8'h0F); check("mask_g1", vi(irq_valid, irq_id), vi(1, 1));
    step(0, 8'h00, 1, 8'h0F);
    step(0, 8'h00, 0, 8'h0F);
    check("mask_none", {31'd0, irq_valid}, 0);
    check("mask_pend", {24'd0, pending}, 32'h80);
    step(0, 8'h00, 0, 8'hFF); check("mask_g7", vi(irq_valid, irq_id), vi(1, 7));
`endif

    // Randomized traffic against the model
    step(1, 8'h00, 0, 8'hFF);
    r_req = 8'h00;
    idle_gap = 0;
    for (int n = 0; n < 3000; n++) begin
      r_req = r_req ^ 8'($urandom & $urandom);
      step(($urandom_range(0, 149) == 0), r_req, $urandom_range(0, 1) == 1, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_pending_arbiter.md
IRQ_PENDING_ARBITER -- requirements
Module: irq_pending_arbiter

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 8 request lines and a 3-bit index.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: clk, rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_in  input  8  raw request lines, one per source, sampled each clk edge.
REQ-006 irq_ready  input  1  downstream accepts the presented index.
REQ-007 irq_valid  output  1  irq_id holds a granted request.
REQ-008 irq_id  output  3  index of the granted source, 3'b111 = bit 7.
REQ-009 pending  output  8  current pending register, for status.
REQ-010 ovf  output  1  sticky flag: a request edge arrived on an already-pending bit.

Function
REQ-011 The block SHALL register req_in into req_prev every cycle; a rising edge on bit i is req_in[i]=1 with req_prev[i]=0 at the same clk edge.
REQ-012 A rising edge on bit i SHALL set pending[i] at that clk edge.
REQ-013 An edge on bit i while pending[i]=1 SHALL leave pending[i]=1 and set ovf=1, held until reset.
REQ-014 The FSM SHALL have two states: IDLE and PRESENT.
REQ-015 In IDLE with any eligible pending bit, the next edge SHALL register irq_id = index of the highest-numbered eligible pending bit, set irq_valid=1 and go to PRESENT.
REQ-016 In IDLE with no eligible pending bit, the FSM SHALL stay in IDLE with irq_valid=0.
REQ-017 In PRESENT, irq_id and irq_valid SHALL hold stable until irq_ready=1.
REQ-018 In PRESENT with irq_ready=1, the next edge SHALL clear pending[irq_id], drive irq_valid=0 and return to IDLE.
REQ-019 Back-to-back grants SHALL be separated by exactly one irq_valid=0 cycle.
REQ-020 If an edge on bit irq_id coincides with its clear, set SHALL win: pending stays 1 and ovf is not set.
REQ-021 Edges on other bits while in PRESENT SHALL update pending without changing the presented irq_id.
REQ-022 Latency: a req_in rise sampled at edge k with the FSM idle and no higher pending bit SHALL give irq_valid=1 after edge k+1.
REQ-023 irq_ready while irq_valid=0 SHALL be ignored.

Reset
REQ-024 With rst=1 at a clk edge, the block SHALL set pending=0, req_prev=0, irq_valid=0, irq_id=3'b000, ovf=0 and the FSM to IDLE.
REQ-025 Reset SHALL override all other events, including a handshake in the same cycle.
REQ-026 A req_in line held high through reset SHALL register as an edge on the first cycle after rst deasserts.

Configuration
REQ-027 The macro IRQ_PENDING_ARBITER_MASK_EN SHALL control masking.
REQ-028 With the macro defined, the block SHALL add the input mask_in (8 bits), where 1 = enabled. A bit is eligible only if pending and mask_in=1. Masked bits still set pending and ovf.
REQ-029 With the macro undefined, the mask_in port SHALL be absent and every pending bit is eligible.
REQ-030 A mask change SHALL NOT alter an irq_id already in PRESENT.

Verification
REQ-031 Reset, then pulse req_in=8'h01 -> irq_valid=1 with irq_id=0 two edges later; irq_ready=1 -> pending=8'h00 and irq_valid=0 on the next edge.
REQ-032 req_in=8'h00 then 8'h94 in one cycle, irq_ready held 1 -> ids granted in order 7, 4, 2, each separated by one idle cycle.
REQ-033 Presenting id 3 with irq_ready=0 while a bit-6 edge arrives -> irq_id stays 3; after ready, the next grant is 6.
REQ-034 Second bit-5 edge while pending[5]=1 and not being cleared -> ovf=1, one grant only; an edge on bit 5 in the clear cycle -> pending[5] remains 1 and ovf is unchanged.
REQ-035 rst=1 in the same cycle as irq_ready=1 with pending=8'hFF -> all outputs 0 next edge; with req_in held at 8'h80 -> pending=8'h80 one edge after reset release.
REQ-036 With the macro defined: mask_in=8'h0F, edges on bits 7 and 1 -> grant 1 only, pending=8'h80 remains; then mask_in=8'hFF -> grant 7.
